// File: rtl/fifo_cnt_cfg_arbiter.sv
// Two-requester arbiter sharing a single AXI4-Lite master port.
// One transaction is outstanding at a time; requesters are served round-robin
// and receive a one-cycle REQ_ACK with the captured read data and response.
module fifo_cnt_cfg_arbiter #(
  parameter int C_M_AXI_ADDR_WIDTH = 4,
  parameter int C_M_AXI_DATA_WIDTH = 32
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  // requester side
  input  logic [1:0]                        REQ,
  input  logic [1:0]                        REQ_WE,
  input  logic [2*C_M_AXI_ADDR_WIDTH-1:0]   REQ_ADDR,
  input  logic [2*C_M_AXI_DATA_WIDTH-1:0]   REQ_WDATA,
  output logic [1:0]                        REQ_ACK,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     REQ_RDATA,
  output logic [1:0]                        REQ_RESP,
  output logic                              GRANT,
  // AXI4-Lite master: write address
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  // write data
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  // write response
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  // read address
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                        M_AXI_ARPROT,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  // read data
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR      = 3'd1;
  localparam logic [2:0] S_WR_RESP = 3'd2;
  localparam logic [2:0] S_RD_ADDR = 3'd3;
  localparam logic [2:0] S_RD_RESP = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]    r_state;
  logic          r_grant;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_awvalid;
  logic          r_wvalid;
  logic          r_bready;
  logic          r_arvalid;
  logic          r_rready;
  logic [DW-1:0] r_rdata;
  logic [1:0]    r_resp;

  logic          w_sel;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wdata;
  logic          w_sel_we;
  logic          w_aw_done;
  logic          w_w_done;

  // Round-robin pick: a lone requester wins; on contention the one not served last wins.
  always_comb begin
    w_sel = REQ[1];
    if (REQ == 2'b11) begin
      w_sel = ~r_grant;
    end
    w_sel_addr  = w_sel ? REQ_ADDR[AW +: AW]  : REQ_ADDR[0 +: AW];
    w_sel_wdata = w_sel ? REQ_WDATA[DW +: DW] : REQ_WDATA[0 +: DW];
    w_sel_we    = w_sel ? REQ_WE[1]           : REQ_WE[0];
  end

  // A write channel counts as finished once its VALID is gone or is handshaking now.
  assign w_aw_done = ~r_awvalid | M_AXI_AWREADY;
  assign w_w_done  = ~r_wvalid  | M_AXI_WREADY;

  // Transaction sequencer: grant, drive the AXI channels, capture the response.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state   <= S_IDLE;
      r_grant   <= 1'b1;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_rdata   <= '0;
      r_resp    <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (REQ != 2'b00) begin
            r_grant <= w_sel;
            r_we    <= w_sel_we;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            if (w_sel_we) begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= S_WR;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= S_RD_ADDR;
            end
          end
        end
        S_WR: begin
          if (M_AXI_AWREADY) r_awvalid <= 1'b0;
          if (M_AXI_WREADY)  r_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_state  <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (M_AXI_BVALID) begin
            r_resp   <= M_AXI_BRESP;
            r_bready <= 1'b0;
            r_state  <= S_DONE;
          end
        end
        S_RD_ADDR: begin
          if (M_AXI_ARREADY) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_RD_RESP;
          end
        end
        S_RD_RESP: begin
          if (M_AXI_RVALID) begin
            r_rdata  <= M_AXI_RDATA;
            r_resp   <= M_AXI_RRESP;
            r_rready <= 1'b0;
            r_state  <= S_DONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // ACK is decoded from the DONE state, so it lasts exactly one cycle.
  assign REQ_ACK   = (r_state == S_DONE) ? (r_grant ? 2'b10 : 2'b01) : 2'b00;
  assign REQ_RDATA = r_rdata;
  assign REQ_RESP  = r_resp;
  assign GRANT     = r_grant;

  assign M_AXI_AWADDR  = r_addr;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = r_awvalid;
  assign M_AXI_WDATA   = r_wdata;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WVALID  = r_wvalid;
  assign M_AXI_BREADY  = r_bready;
  assign M_AXI_ARADDR  = r_addr;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = r_arvalid;
  assign M_AXI_RREADY  = r_rready;

endmodule

// File: tb/tb_fifo_cnt_cfg_arbiter.sv
// Directed bench for fifo_cnt_cfg_arbiter with a small AXI4-Lite slave model.
module tb_fifo_cnt_cfg_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  REQ = '0;
  logic [1:0]  REQ_WE = '0;
  logic [7:0]  REQ_ADDR = '0;
  logic [63:0] REQ_WDATA = '0;
  logic [1:0]  REQ_ACK;
  logic [31:0] REQ_RDATA;
  logic [1:0]  REQ_RESP;
  logic        GRANT;
  logic [3:0]  AWADDR;
  logic [2:0]  AWPROT;
  logic        AWVALID;
  logic        AWREADY = 1'b0;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY = 1'b0;
  logic [1:0]  BRESP = '0;
  logic        BVALID = 1'b0;
  logic        BREADY;
  logic [3:0]  ARADDR;
  logic [2:0]  ARPROT;
  logic        ARVALID;
  logic        ARREADY = 1'b0;
  logic [31:0] RDATA = '0;
  logic [1:0]  RRESP = '0;
  logic        RVALID = 1'b0;
  logic        RREADY;

  fifo_cnt_cfg_arbiter #(.C_M_AXI_ADDR_WIDTH(4), .C_M_AXI_DATA_WIDTH(32)) dut (
    .ACLK(clk), .ARESET(rst),
    .REQ(REQ), .REQ_WE(REQ_WE), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
    .REQ_ACK(REQ_ACK), .REQ_RDATA(REQ_RDATA), .REQ_RESP(REQ_RESP), .GRANT(GRANT),
    .M_AXI_AWADDR(AWADDR), .M_AXI_AWPROT(AWPROT), .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
    .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
    .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY),
    .M_AXI_ARADDR(ARADDR), .M_AXI_ARPROT(ARPROT), .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
    .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY)
  );

  always #5 clk = ~clk;

  // slave configuration and state
  int          aw_dly = 0, w_dly = 0, aw_cnt = 0, w_cnt = 0;
  logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
  logic        b_hold = 1'b0;
  logic        have_aw = 1'b0, have_w = 1'b0;
  logic [3:0]  s_awaddr = '0, s_araddr = '0;
  logic [31:0] s_wdata = '0;
  logic [31:0] mem [4] = '{default: 32'h0};
  int          aw_hs = 0, w_hs = 0, ar_hs = 0;

  int n_checks = 0;
  int n_fail = 0;

  // Slave responses are decided on the falling edge for the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0;
      have_aw = 0; have_w = 0; aw_cnt = 0; w_cnt = 0;
    end else begin
      if (AWVALID && !have_aw) begin
        if (aw_cnt >= aw_dly) begin AWREADY = 1; have_aw = 1; s_awaddr = AWADDR; end
        else begin AWREADY = 0; aw_cnt++; end
      end else begin AWREADY = 0; aw_cnt = 0; end
      if (WVALID && !have_w) begin
        if (w_cnt >= w_dly) begin WREADY = 1; have_w = 1; s_wdata = WDATA; end
        else begin WREADY = 0; w_cnt++; end
      end else begin WREADY = 0; w_cnt = 0; end
      if (BREADY && have_aw && have_w && !b_hold) begin
        if (!BVALID) mem[s_awaddr[3:2]] = s_wdata;
        BVALID = 1; BRESP = cfg_bresp;
      end else begin
        if (BVALID) begin have_aw = 0; have_w = 0; end
        BVALID = 0;
      end
      if (ARVALID && !ARREADY) begin ARREADY = 1; s_araddr = ARADDR; end
      else ARREADY = 0;
      if (RREADY) begin RVALID = 1; RDATA = mem[s_araddr[3:2]]; RRESP = cfg_rresp; end
      else RVALID = 0;
    end
  end

  // Handshake counters.
  always @(posedge clk) begin
    if (!rst) begin
      if (AWVALID && AWREADY) aw_hs++;
      if (WVALID && WREADY) w_hs++;
      if (ARVALID && ARREADY) ar_hs++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ack(output logic got);
    got = 0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      if (REQ_ACK != 2'b00) got = 1;
    end
  endtask

  task automatic do_txn(input logic n, input logic we, input logic [3:0] addr,
                        input logic [31:0] wdata, input logic [1:0] exp_resp,
                        input logic [31:0] exp_rdata);
    logic got;
    aw_hs = 0; w_hs = 0; ar_hs = 0;
    REQ_WE[n] = we;
    REQ_ADDR[int'(n)*4 +: 4] = addr;
    REQ_WDATA[int'(n)*32 +: 32] = wdata;
    REQ[n] = 1'b1;
    wait_ack(got);
    check("ack_seen", {31'd0, got}, 32'd1);
    if (got) begin
      check("ack_onehot", {30'd0, REQ_ACK}, n ? 32'd2 : 32'd1);
      check("grant", {31'd0, GRANT}, {31'd0, n});
      check("resp", {30'd0, REQ_RESP}, {30'd0, exp_resp});
      check("rdata", REQ_RDATA, exp_rdata);
      if (we) begin
        check("aw_handshakes", aw_hs, 32'd1);
        check("w_handshakes", w_hs, 32'd1);
      end else begin
        check("ar_handshakes", ar_hs, 32'd1);
      end
    end
    REQ[n] = 1'b0;
    @(negedge clk);
    check("ack_one_cycle", {30'd0, REQ_ACK}, 32'd0);
    $display("txn req%0d we=%0d addr=0x%0h wdata=0x%0h -> rdata=0x%0h resp=%0d grant=%0d",
             n, we, addr, wdata, REQ_RDATA, REQ_RESP, GRANT);
  endtask

  typedef struct {
    logic        n;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    int          awd;
    int          wd;
    logic [1:0]  bresp;
    logic [1:0]  rresp;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic got;
    vecs[0] = '{1'b0, 1'b1, 4'h4, 32'h00000002, 0, 0, 2'b00, 2'b00, 2'b00, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 4'h8, 32'h00000003, 0, 0, 2'b00, 2'b00, 2'b00, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 4'h8, 32'h0,        0, 0, 2'b00, 2'b00, 2'b00, 32'h3};
    vecs[3] = '{1'b0, 1'b0, 4'h4, 32'h0,        0, 0, 2'b00, 2'b00, 2'b00, 32'h2};
    vecs[4] = '{1'b0, 1'b1, 4'h0, 32'h0000A5A5, 0, 3, 2'b00, 2'b00, 2'b00, 32'h2};
    vecs[5] = '{1'b1, 1'b1, 4'hC, 32'h00001234, 3, 0, 2'b10, 2'b00, 2'b10, 32'h2};
    vecs[6] = '{1'b1, 1'b0, 4'h8, 32'h0,        0, 0, 2'b00, 2'b10, 2'b10, 32'h3};
    vecs[7] = '{1'b0, 1'b0, 4'h0, 32'h0,        0, 0, 2'b00, 2'b00, 2'b00, 32'hA5A5};

    // reset state
    repeat (3) @(negedge clk);
    check("rst_grant", {31'd0, GRANT}, 32'd1);
    check("rst_ack", {30'd0, REQ_ACK}, 32'd0);
    check("rst_rdata", REQ_RDATA, 32'd0);
    check("rst_resp", {30'd0, REQ_RESP}, 32'd0);
    check("rst_valid_ready", {27'd0, AWVALID, WVALID, ARVALID, BREADY, RREADY}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      aw_dly = vecs[i].awd; w_dly = vecs[i].wd;
      cfg_bresp = vecs[i].bresp; cfg_rresp = vecs[i].rresp;
      do_txn(vecs[i].n, vecs[i].we, vecs[i].addr, vecs[i].wdata,
             vecs[i].exp_resp, vecs[i].exp_rdata);
    end
    aw_dly = 0; w_dly = 0; cfg_bresp = 2'b00; cfg_rresp = 2'b00;
    check("prot_strb", {25'd0, AWPROT, ARPROT, WSTRB == 4'hF}, 32'd1);

    // contention from reset: both requesters hold REQ, grants must alternate 0,1,0,1
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    REQ_WE = 2'b00;
    REQ_ADDR = {4'h8, 4'h4};
    REQ = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_ack(got);
      check("rr_ack_seen", {31'd0, got}, 32'd1);
      if (got) begin
        check("rr_ack_onehot", {30'd0, REQ_ACK}, (k % 2) ? 32'd2 : 32'd1);
        check("rr_grant", {31'd0, GRANT}, k % 2);
      end
      $display("rr round %0d ack=%b grant=%0d", k, REQ_ACK, GRANT);
    end
    REQ = 2'b00;
    @(negedge clk);

    // reset while waiting for the write response
    b_hold = 1'b1;
    REQ_WE[0] = 1'b1;
    REQ_ADDR[3:0] = 4'h4;
    REQ_WDATA[31:0] = 32'h000000FF;
    REQ[0] = 1'b1;
    got = 0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      if (BREADY) got = 1;
    end
    check("bready_reached", {31'd0, got}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_bready_low", {31'd0, BREADY}, 32'd0);
    check("rst_mid_ack", {30'd0, REQ_ACK}, 32'd0);
    REQ[0] = 1'b0;
    got = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (REQ_ACK != 2'b00) got = 1;
    end
    check("no_ack_in_reset", {31'd0, got}, 32'd0);
    b_hold = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    $display("reset during WR_RESP applied and released");
    do_txn(1'b0, 1'b0, 4'h4, 32'h0, 2'b00, 32'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
